sp_mem_arbiter: RTL and testbench

// - Shares one single-port, byte-enabled, 1-cycle sync-read memory among NUM_REQ requesters.
// - Round-robin arbitration with optional bounded burst lock; at most one access per cycle.
// - Routes each read response back to its issuer; sits between bus-side masters and the RAM macro.

---
 rtl/sp_mem_arbiter_pkg.sv | 14 +
 rtl/sp_mem_arbiter_if.sv | 36 +++
 rtl/sp_mem_arbiter_rr_arbiter.sv | 30 +++
 rtl/sp_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_sp_mem_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/sp_mem_arbiter_pkg.sv
// Shared types and helpers for the single-port memory arbiter.
package sp_mem_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width that stays >= 1 even for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_mem_arbiter_if.sv
// Requester-side handshake plus RAM-macro bus of the single-port memory arbiter.
interface sp_mem_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 10
) ();

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           req_we;
  logic [NUM_REQ-1:0]           req_lock;
  logic [NUM_REQ*AW-1:0]        req_addr;
  logic [NUM_REQ*WIDTH-1:0]     req_wdata;
  logic [NUM_REQ*WIDTH/8-1:0]   req_wstrb;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [WIDTH-1:0]             rsp_rdata;
  logic                         mem_cs;
  logic                         mem_we;
  logic [AW-1:0]                mem_addr;
  logic [WIDTH-1:0]             mem_wdata;
  logic [WIDTH/8-1:0]           mem_wstrb;
  logic [WIDTH-1:0]             mem_rdata;

  // Arbiter view.
  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Requesters plus RAM macro view.
  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/sp_mem_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] sel;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel = IW'((32'(ptr) + k) % N);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one 1-cycle sync-read RAM;
// routes read data back to the issuing requester.
module sp_mem_arbiter
  import sp_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned MAX_BURST = 8
) (
  input logic          clk,
  input logic          rst_n,
  sp_mem_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = WIDTH / 8;
  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] tag_q, tag_d;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IW-1:0]      rr_idx;
  logic               rr_found;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               accept;
  logic [IW-1:0]      gidx_nxt;
  logic [IW-1:0]      owner_nxt;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Grant is forced to zero while reset is held so the RAM sees no access.
  always_comb begin
    grant = '0;
    gidx  = '0;
    if (rst_n) begin
      if (state_q == ARB) begin
        grant = rr_found ? rr_gnt : '0;
        gidx  = rr_idx;
      end else begin
        grant[owner_q] = bus.req_valid[owner_q];
        gidx           = owner_q;
      end
    end
  end

  assign accept    = |grant;
  assign gidx_nxt  = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign owner_nxt = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign bus.req_ready = grant;

  always_comb begin
    bus.mem_cs    = accept;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    if (accept) begin
      bus.mem_we    = bus.req_we[gidx];
      bus.mem_addr  = bus.req_addr[gidx*AW +: AW];
      bus.mem_wdata = bus.req_wdata[gidx*WIDTH +: WIDTH];
      bus.mem_wstrb = bus.req_wstrb[gidx*SW +: SW];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tag_d   = (accept && !bus.req_we[gidx]) ? grant : '0;
    case (state_q)
      ARB: begin
        if (accept) begin
          ptr_d = gidx_nxt;
          if (bus.req_lock[gidx] && (MAX_BURST > 1)) begin
            state_d = LOCK;
            owner_d = gidx;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCK: begin
        // In LOCK the owner is always ready, so valid[owner] means an accept.
        if (!bus.req_valid[owner_q]) begin
          state_d = ARB;
          ptr_d   = owner_nxt;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!bus.req_lock[owner_q] || ((32'(cnt_q) + 1) >= MAX_BURST)) begin
            state_d = ARB;
            ptr_d   = owner_nxt;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.rsp_valid = tag_q;
  assign bus.rsp_rdata = (|tag_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed bench: arbiter in front of a behavioural 1-cycle sync-read byte-enabled RAM.
module tb_sp_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 10;

  logic clk;
  logic rst_n;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [3:0]    vld, lck, wen;
  logic [AW-1:0] a [N];
  logic [W-1:0]  d [N];
  logic [3:0]    s [N];

  logic [W-1:0]  ram [1024];
  logic [W-1:0]  ram_q;

  sp_mem_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .AW(AW)) bus ();

  sp_mem_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .DEPTH     (1024),
    .MAX_BURST (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_comb begin
    bus.req_valid = vld;
    bus.req_lock  = lck;
    bus.req_we    = wen;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = a[i];
      bus.req_wdata[i*W +: W]  = d[i];
      bus.req_wstrb[i*4 +: 4]  = s[i];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end else begin
        ram_q <= ram[bus.mem_addr];
      end
    end
  end
  assign bus.mem_rdata = ram_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, check the combinational grant, then the response after the edge.
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] l,
                      input logic [3:0] w, input logic [3:0] rdy, input logic [31:0] rd);
    vld = v;
    lck = l;
    wen = w;
    #1;
    check({tag, "_rdy"}, bus.req_ready, rdy);
    check({tag, "_cs"}, bus.mem_cs, |rdy);
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) begin
        check({tag, "_we"}, bus.mem_we, w[i]);
        check({tag, "_addr"}, bus.mem_addr, a[i]);
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_rsp"}, bus.rsp_valid, rdy & ~w);
    if (|(rdy & ~w)) check({tag, "_rdata"}, bus.rsp_rdata, rd);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    vld = '0;
    lck = '0;
    wen = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(5);
      d[i] = 32'hA5A5_1234;
      s[i] = 4'hF;
    end

    #12;
    check("rst_ready", bus.req_ready, 4'b0000);
    check("rst_rsp", bus.rsp_valid, 4'b0000);
    check("rst_cs", bus.mem_cs, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write then read of address 5 by requester 0.
    step("wr5",  4'b0001, 4'b0000, 4'b0001, 4'b0001, 32'h0);
    step("rd5",  4'b0001, 4'b0000, 4'b0000, 4'b0001, 32'hA5A5_1234);
    step("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0);

    // Byte strobes on address 7.
    a[0] = AW'(7);
    d[0] = 32'hFFFF_FFFF;
    step("wr7f", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 32'h0);
    d[0] = 32'h0000_AB00;
    s[0] = 4'h2;
    step("wr7b", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 32'h0);
    step("rd7",  4'b0001, 4'b0000, 4'b0000, 4'b0001, 32'hFFFF_ABFF);
    a[0] = AW'(5);
    d[0] = 32'hA5A5_1234;
    s[0] = 4'hF;

    // Write by r3 moves ptr to 0, then all four read continuously.
    step("wr_r3", 4'b1000, 4'b0000, 4'b1000, 4'b1000, 32'h0);
    for (int k = 0; k < 8; k++)
      step($sformatf("rr%0d", k), 4'b1111, 4'b0000, 4'b0000, 4'(1 << (k % 4)), 32'hA5A5_1234);

    // Write by r1 moves ptr to 2; r2 locks while r0 and r1 stay valid.
    step("wr_r1", 4'b0010, 4'b0000, 4'b0010, 4'b0010, 32'h0);
    step("lk1",  4'b0111, 4'b0100, 4'b0000, 4'b0100, 32'hA5A5_1234);
    step("lk2",  4'b0111, 4'b0100, 4'b0000, 4'b0100, 32'hA5A5_1234);
    step("lk3",  4'b0111, 4'b0100, 4'b0000, 4'b0100, 32'hA5A5_1234);
    step("lk4",  4'b0111, 4'b0100, 4'b0000, 4'b0100, 32'hA5A5_1234);
    step("lk5",  4'b0111, 4'b0100, 4'b0000, 4'b0001, 32'hA5A5_1234);
    step("lk6",  4'b0111, 4'b0100, 4'b0000, 4'b0010, 32'hA5A5_1234);
    step("lk7",  4'b0111, 4'b0100, 4'b0000, 4'b0100, 32'hA5A5_1234);
    step("lk8",  4'b0111, 4'b0100, 4'b0000, 4'b0100, 32'hA5A5_1234);
    step("lk9",  4'b0011, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    step("lk10", 4'b0011, 4'b0000, 4'b0000, 4'b0001, 32'hA5A5_1234);

    // Idle release: r1 locks, drops valid after two beats, r2 follows.
    step("ir1", 4'b0110, 4'b0010, 4'b0000, 4'b0010, 32'hA5A5_1234);
    step("ir2", 4'b0110, 4'b0010, 4'b0000, 4'b0010, 32'hA5A5_1234);
    step("ir3", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    step("ir4", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 32'hA5A5_1234);

    // Reset while r0 holds the lock and a response is on the bus.
    step("rl1", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 32'hA5A5_1234);
    step("rl2", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 32'hA5A5_1234);
    check("pre_rst_ready", bus.req_ready, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.req_ready, 4'b0000);
    check("mid_rst_rsp", bus.rsp_valid, 4'b0000);
    check("mid_rst_cs", bus.mem_cs, 1'b0);
    check("mid_rst_rdata", bus.rsp_rdata, 32'h0);
    vld = 4'b0000;
    lck = 4'b0000;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_rsp", bus.rsp_valid, 4'b0000);
    step("rst_first", 4'b1010, 4'b0000, 4'b0000, 4'b0010, 32'hA5A5_1234);
    step("rst_idle",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
